// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for the shared adder arbiter.
// rsp_cout is present only when ADDER_COUT_EN is defined.
interface adder_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
`ifdef ADDER_COUT_EN
    logic                  rsp_cout;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
`endif
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters.
// Define ADDER_COUT_EN to add the registered rsp_cout output.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_valid;
    logic [IDW-1:0]   w_win;
    logic [IDW:0]     w_idx;
    logic             w_found;
    logic             w_take;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-2:0] w_c;

    // First valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_found && bus.req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    assign w_take    = (r_state == S_IDLE) && w_found;
    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

    always_comb begin
        w_ready = '0;
        if (w_take && rst_n)
            w_ready = NREQ'(1) << w_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_found) w_next = S_ADD;
            S_ADD:  w_next = S_RESP;
            S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ripple chain: half adder at bit 0, full adders above
    assign w_sum[0] = r_a[0] ^ r_b[0];
    assign w_c[0]   = r_a[0] & r_b[0];
    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        assign w_sum[i] = r_a[i] ^ r_b[i] ^ w_c[i-1];
        if (i < WIDTH - 1) begin : g_c
            assign w_c[i] = (r_a[i] & r_b[i]) | (w_c[i-1] & (r_a[i] ^ r_b[i]));
        end
    end

`ifdef ADDER_COUT_EN
    logic w_cout;
    logic r_cout;
    assign w_cout = (r_a[WIDTH-1] & r_b[WIDTH-1])
                  | (w_c[WIDTH-2] & (r_a[WIDTH-1] ^ r_b[WIDTH-1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cout <= 1'b0;
        else if (r_state == S_ADD)
            r_cout <= w_cout;
    end

    assign bus.rsp_cout = r_cout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_gid    <= '0;
            r_rsp_id <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_take) begin
                r_a   <= bus.req_a[w_win*WIDTH +: WIDTH];
                r_b   <= bus.req_b[w_win*WIDTH +: WIDTH];
                r_gid <= w_win;
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == S_ADD) begin
                r_sum    <= w_sum;
                r_rsp_id <= r_gid;
                r_valid  <= 1'b1;
            end
            if (r_state == S_RESP && bus.rsp_ready)
                r_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_sum;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized + directed bench for adder_share_arbiter against a transaction model.
// Build with +define+ADDER_COUT_EN to also check rsp_cout.
module tb_adder_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    adder_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model
    int          m_ptr;
    bit          m_busy;
    bit          m_valid;
    logic [31:0] m_pa, m_pb;
    int          m_pid;
    logic [31:0] m_last_sum;
    int          m_last_id;
    logic        m_last_cout;
    int          m_log[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int winner(logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int logat(int i);
        if (i < m_log.size()) return m_log[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_busy = 0; m_valid = 0;
        m_last_sum = '0; m_last_id = 0; m_last_cout = 1'b0;
    endtask

    task automatic model_update();
        int w;
        logic [32:0] s;
        if (m_valid) begin
            if (bus.rsp_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end else if (m_busy) begin
            s = {1'b0, m_pa} + {1'b0, m_pb};
            m_last_sum  = s[31:0];
            m_last_cout = s[32];
            m_last_id   = m_pid;
            m_valid     = 1;
        end else begin
            w = winner(bus.req_valid);
            if (w >= 0) begin
                m_pa   = bus.req_a[w*WIDTH +: WIDTH];
                m_pb   = bus.req_b[w*WIDTH +: WIDTH];
                m_pid  = w;
                m_busy = 1;
                m_ptr  = (w + 1) % NREQ;
                m_log.push_back(w);
            end
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] er;
        int w;
        er = '0;
        if (rst_n && !m_busy) begin
            w = winner(bus.req_valid);
            if (w >= 0) er[w] = 1'b1;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_last_id));
        chk("rsp_sum", 64'(bus.rsp_sum), 64'(m_last_sum));
`ifdef ADDER_COUT_EN
        chk("rsp_cout", 64'(bus.rsp_cout), 64'(m_last_cout));
`endif
    endtask

    // One clock: check at negedge, advance model at posedge, return 1 after it
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        #3;
        step();
        step();
        chk("reset_sum", 64'(bus.rsp_sum), 64'd0);
        chk("reset_id", 64'(bus.rsp_id), 64'd0);
        rst_n = 1'b1;

        // Single request from requester 1
        bus.rsp_ready = 1'b1;
        set_req(1, 32'd5, 32'd7);
        bus.req_valid = 4'b0010;
        #1;
        chk("t1_ready", 64'(bus.req_ready), 64'b0010);
        step();
        bus.req_valid = '0;
        step();
        chk("t1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_id", 64'(bus.rsp_id), 64'd1);
        chk("t1_sum", 64'(bus.rsp_sum), 64'd12);
        step();
        step();

        // Wrap-around arithmetic
        set_req(0, 32'hFFFF_FFFF, 32'h1);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        step();
        chk("t3_sum_ff", 64'(bus.rsp_sum), 64'd0);
        chk("t3_model_ff", 64'(m_last_sum), 64'd0);
`ifdef ADDER_COUT_EN
        chk("t3_cout_ff", 64'(bus.rsp_cout), 64'd1);
`endif
        step();
        set_req(0, 32'h8000_0000, 32'h8000_0000);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        step();
        chk("t3_sum_80", 64'(bus.rsp_sum), 64'd0);
`ifdef ADDER_COUT_EN
        chk("t3_cout_80", 64'(bus.rsp_cout), 64'd1);
`endif
        step();

        // All valid: grants 0,1,2,3,0
        do_reset();
        bus.req_valid = 4'b1111;
        m_log.delete();
        repeat (15) step();
        chk("t2_n", 64'(m_log.size()), 64'd5);
        chk("t2_g0", 64'(logat(0)), 64'd0);
        chk("t2_g1", 64'(logat(1)), 64'd1);
        chk("t2_g2", 64'(logat(2)), 64'd2);
        chk("t2_g3", 64'(logat(3)), 64'd3);
        chk("t2_g4", 64'(logat(4)), 64'd0);

        // Fairness between 0 and 2
        do_reset();
        bus.req_valid = 4'b0101;
        m_log.delete();
        repeat (12) step();
        chk("t5_g0", 64'(logat(0)), 64'd0);
        chk("t5_g1", 64'(logat(1)), 64'd2);
        chk("t5_g2", 64'(logat(2)), 64'd0);
        chk("t5_g3", 64'(logat(3)), 64'd2);

        // Backpressure in RESP (ptr is 3 here)
        bus.req_valid = '0;
        step();
        set_req(3, 32'd100, 32'd23);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 4'b1111;
        step();
        repeat (10) step();
        chk("t4_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t4_sum", 64'(bus.rsp_sum), 64'd123);
        chk("t4_ready0", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        step();
        chk("t4_done", 64'(bus.rsp_valid), 64'd0);
        chk("t4_next", 64'(bus.req_ready), 64'b0001);
        step();

        // Reset during ADD
        do_reset();
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b1010;
        do_reset();
        m_log.delete();
        step();
        chk("t6_add_g", 64'(logat(0)), 64'd1);
        repeat (3) step();

        // Reset during RESP
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = '0;
        step();
        step();
        chk("t6_in_resp", 64'(bus.rsp_valid), 64'd1);
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        do_reset();
        m_log.delete();
        step();
        chk("t6_resp_g", 64'(logat(0)), 64'd1);
        repeat (3) step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, pick(), pick());
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
